// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// It keeps shadow copies of the digit nibbles, decimal points and the
// leading-zero enable. It shows one digit per slot of SCAN_DIV cycles. The first
// cycle of every slot is blank so that the previous digit does not ghost
// into the next one.
//
// Parameters:
//   DIGITS   number of scanned digits (>= 2)
//   SCAN_DIV cycles per digit slot, blank cycle included (>= 2)
//   HEX_EN   0: codes 10-15 blank, 1: codes 10-15 show A b C d E F
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   digit_values nibble i = digit i; digit 0 is the rightmost
//   dp_in        decimal point per digit, 1 = lit
//   blank_lz     leading-zero suppression enable
//   load         capture strobe for digit_values / dp_in / blank_lz
//   seg_data     active-low {dp,g,f,e,d,c,b,a}, registered
//   digit_sel    active-low one-hot digit enable, registered
//   frame_done   one-cycle pulse after the last slot of a frame

module seven_seg_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int HEX_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_values,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [7:0]            seg_data,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    // Active-low segments [6:0] = {g,f,e,d,c,b,a} for one nibble.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] g;
        g = 7'h7F;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h58;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = (HEX_EN != 0) ? 7'h08 : 7'h7F;
            4'hB: g = (HEX_EN != 0) ? 7'h03 : 7'h7F;
            4'hC: g = (HEX_EN != 0) ? 7'h46 : 7'h7F;
            4'hD: g = (HEX_EN != 0) ? 7'h21 : 7'h7F;
            4'hE: g = (HEX_EN != 0) ? 7'h06 : 7'h7F;
            4'hF: g = (HEX_EN != 0) ? 7'h0E : 7'h7F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Shadow registers: the display only ever looks at these.
    logic [4*DIGITS-1:0] vals_reg;
    logic [DIGITS-1:0]   dp_reg;
    logic                lz_reg;

    // Scan position.
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;

    // Output registers.
    logic [7:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   sel_reg, sel_next;
    logic                frame_reg, frame_next;

    logic                slot_end;
    logic                last_digit;

    // Per-digit rendered glyph including decimal point.
    logic [7:0]          glyph   [DIGITS];
    logic [DIGITS-1:0]   lz_kill;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // A digit is a leading zero when it and every more significant
            // nibble are zero. The rightmost digit always stays visible.
            if (gi == 0) begin : g_lsd
                assign lz_kill[gi] = 1'b0;
            end else begin : g_upper
                assign lz_kill[gi] = lz_reg && (vals_reg[4*DIGITS-1:4*gi] == '0);
            end

            // dp is independent of suppression and of the glyph itself.
            assign glyph[gi] = {~dp_reg[gi],
                                lz_kill[gi] ? 7'h7F : decode(vals_reg[4*gi +: 4])};
        end
    endgenerate

    assign slot_end   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));

    always_comb begin
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        seg_next   = 8'hFF;
        sel_next   = '1;
        frame_next = slot_end && last_digit;

        if (slot_end) begin
            cnt_next = '0;
            idx_next = last_digit ? '0 : idx_reg + IDX_W'(1);
        end

        // Slot cycle 0 is the anti-ghosting blank gap.
        if (cnt_reg != '0) begin
            sel_next = ~(DIGITS'(1) << idx_reg);
            seg_next = glyph[idx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vals_reg  <= '0;
            dp_reg    <= '0;
            lz_reg    <= 1'b0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            seg_reg   <= 8'hFF;
            sel_reg   <= '1;
            frame_reg <= 1'b0;
        end else begin
            if (load) begin
                vals_reg <= digit_values;
                dp_reg   <= dp_in;
                lz_reg   <= blank_lz;
            end
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            seg_reg   <= seg_next;
            sel_reg   <= sel_next;
            frame_reg <= frame_next;
        end
    end

    assign seg_data   = seg_reg;
    assign digit_sel  = sel_reg;
    assign frame_done = frame_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with DIGITS=4, SCAN_DIV=4. Two instances share the
// stimulus: one with HEX_EN=0 and one with HEX_EN=1. A frame-position model
// predicts every output on every cycle. Directed steps pin the model with
// hand-computed glyphs.

module tb_seven_seg_scan;

    localparam int DIGITS = 4;
    localparam int SD     = 4;
    localparam int PERIOD = DIGITS * SD;

    localparam logic [7:0] GLYPH_DEC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [7:0] GLYPH_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digit_values = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        load = 1'b0;

    logic [7:0]  seg0, seg1;
    logic [3:0]  sel0, sel1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SD), .HEX_EN(0)) u_dec (
        .clk(clk), .rst(rst), .digit_values(digit_values), .dp_in(dp_in),
        .blank_lz(blank_lz), .load(load),
        .seg_data(seg0), .digit_sel(sel0), .frame_done(fd0));

    seven_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SD), .HEX_EN(1)) u_hex (
        .clk(clk), .rst(rst), .digit_values(digit_values), .dp_in(dp_in),
        .blank_lz(blank_lz), .load(load),
        .seg_data(seg1), .digit_sel(sel1), .frame_done(fd1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos = cycles since reset release, modulo the frame period.
    logic [15:0] m_vals;
    logic [3:0]  m_dp;
    logic        m_lz;
    int          m_pos;
    int          m_d, m_s;
    logic [7:0]  exp_seg0, exp_seg1;
    logic [3:0]  exp_sel;
    logic        exp_fd;
    bit          m_valid = 1'b0;

    function automatic logic [7:0] model_seg(input int d, input bit hex);
        logic [3:0] nib;
        logic [7:0] g;
        bit         allz;
        nib = m_vals[d*4 +: 4];
        g   = hex ? GLYPH_HEX[nib] : GLYPH_DEC[nib];
        if (m_lz && d > 0) begin
            allz = 1'b1;
            for (int j = d; j < DIGITS; j++)
                if (m_vals[j*4 +: 4] != 4'h0) allz = 1'b0;
            if (allz) g = 8'hFF;
        end
        g[7] = ~m_dp[d];
        return g;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_vals = '0; m_dp = '0; m_lz = 1'b0; m_pos = 0;
            exp_seg0 = 8'hFF; exp_seg1 = 8'hFF; exp_sel = 4'hF; exp_fd = 1'b0;
        end else begin
            m_d = m_pos / SD;
            m_s = m_pos % SD;
            if (m_s == 0) begin
                exp_sel  = 4'hF;
                exp_seg0 = 8'hFF;
                exp_seg1 = 8'hFF;
            end else begin
                exp_sel  = 4'hF & ~(4'b0001 << m_d);
                exp_seg0 = model_seg(m_d, 1'b0);
                exp_seg1 = model_seg(m_d, 1'b1);
            end
            exp_fd = (m_pos == PERIOD - 1);
            m_pos  = (m_pos + 1) % PERIOD;
            if (load) begin
                m_vals = digit_values;
                m_dp   = dp_in;
                m_lz   = blank_lz;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_seg_dec", seg0, exp_seg0);
            check("model_seg_hex", seg1, exp_seg1);
            check("model_sel_dec", sel0, exp_sel);
            check("model_sel_hex", sel1, exp_sel);
            check("model_fd_dec",  fd0,  exp_fd);
            check("model_fd_hex",  fd1,  exp_fd);
        end
    end

    // frame_done spacing
    int cyc = 0;
    int last_fd = 0;
    bit have_last = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst) begin
            have_last = 1'b0;
        end else if (fd0) begin
            if (have_last) check("frame_spacing", cyc - last_fd, PERIOD);
            last_fd   = cyc;
            have_last = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] target, input string name);
        int n;
        n = 0;
        while (sel0 !== target && n < 64) begin
            tick();
            n++;
        end
        check(name, sel0, target);
    endtask

    logic [3:0] rs_sel [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
    logic [7:0] rs_seg [8] = '{8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hC0, 8'hC0, 8'hC0};

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_seg", seg0, 8'hFF);
        check("rst_sel", sel0, 4'hF);
        check("rst_fd",  fd0,  1'b0);
        $display("reset held: seg=%h sel=%b fd=%b", seg0, sel0, fd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("startup_sel", sel0, rs_sel[k]);
            check("startup_seg", seg0, rs_seg[k]);
            $display("startup cycle %0d: seg=%h sel=%b", k + 1, seg0, sel0);
        end

        // decode sweep on digit 0
        for (int c = 0; c < 16; c++) begin
            digit_values = 16'(c);
            pulse_load();
            tick();
            wait_sel(4'hE, "sweep_wait");
            check("sweep_dec", seg0, GLYPH_DEC[c]);
            check("sweep_hex", seg1, GLYPH_HEX[c]);
            $display("code %h: dec=%h hex=%h", c[3:0], seg0, seg1);
        end

        // leading-zero suppression
        digit_values = 16'h0030;
        dp_in        = 4'b0100;
        blank_lz     = 1'b1;
        pulse_load();
        tick();
        wait_sel(4'h7, "lz_wait3"); check("lz_d3", seg0, 8'hFF);
        wait_sel(4'hB, "lz_wait2"); check("lz_d2", seg0, 8'h7F);
        wait_sel(4'hD, "lz_wait1"); check("lz_d1", seg0, 8'hB0);
        wait_sel(4'hE, "lz_wait0"); check("lz_d0", seg0, 8'hC0);
        $display("lz on: digits 3..1 checked, d0=%h", seg0);
        blank_lz = 1'b0;
        pulse_load();
        tick();
        wait_sel(4'h7, "nolz_wait3"); check("nolz_d3", seg0, 8'hC0);
        $display("lz off: d3=%h", seg0);

        // live inputs without load do not reach the display
        digit_values = 16'h1111;
        tick();
        wait_sel(4'hE, "noload_wait"); check("noload_d0", seg0, 8'hC0);
        $display("no load: d0=%h", seg0);

        // load while digit 0 is lit: new glyph exactly two cycles later
        wait_sel(4'hF, "mid_wait_blank");
        wait_sel(4'hE, "mid_wait_lit");
        digit_values = 16'h0005;
        pulse_load();
        check("mid_t1_seg", seg0, 8'hC0);
        check("mid_t1_sel", sel0, 4'hE);
        tick();
        check("mid_t2_seg", seg0, 8'h92);
        check("mid_t2_sel", sel0, 4'hE);
        tick();
        check("mid_t3_sel", sel0, 4'hF);
        tick();
        check("mid_t4_sel", sel0, 4'hD);
        check("mid_t4_seg", seg0, 8'hC0);
        $display("mid-slot load: d1=%h sel=%b", seg0, sel0);

        // reset while digit 2 is lit
        wait_sel(4'hB, "mrst_wait");
        rst = 1'b1;
        tick();
        check("mrst_seg", seg0, 8'hFF);
        check("mrst_sel", sel0, 4'hF);
        check("mrst_fd",  fd0,  1'b0);
        rst = 1'b0;
        tick();
        check("mrst_c1_sel", sel0, 4'hF);
        tick();
        check("mrst_c2_sel", sel0, 4'hE);
        check("mrst_c2_seg", seg0, 8'hC0);
        $display("mid-scan reset: restart seg=%h sel=%b", seg0, sel0);

        repeat (40) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a common-anode multi-digit seven-segment display. It holds a shadow copy of DIGITS BCD/hex nibbles plus decimal points, scans them one digit at a time through a shared active-low segment bus, and inserts a one-cycle blanking gap between digits to prevent ghosting. It also supports optional hex glyphs and leading-zero suppression. It sits between the Locker control logic and the board pins, replacing per-digit static decoders.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥ 2.
- SCAN_DIV, 50000: clock cycles per digit slot, blank cycle included; must be ≥ 2.
- HEX_EN, 0: 0 = codes 10–15 render blank; 1 = codes 10–15 render A, b, C, d, E, F.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- digit_values  in  4*DIGITS  nibble i = digit i, bits [4i+3:4i]; digit 0 is least significant/rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  leading-zero suppression enable.
- load  in  1  single-cycle strobe that captures digit_values, dp_in and blank_lz into shadow registers.
- seg_data  out  8  active-low segments {dp,g,f,e,d,c,b,a}; registered.
- digit_sel  out  DIGITS  active-low one-hot digit enable; registered.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Shadow registers (values, dp, lz): written only on a cycle where load=1. The display always uses the shadow registers, never the live inputs.
- Slot counter cnt: counts 0..SCAN_DIV-1, then wraps to 0.
- Digit index idx:
  - Increments when cnt = SCAN_DIV-1.
  - Wraps from DIGITS-1 to 0.
- Output register update, every cycle:
  - If cnt = 0: seg_data ← 8'hFF, digit_sel ← all ones (blank gap).
  - Otherwise: digit_sel ← all ones except bit idx = 0, and seg_data ← glyph(idx).
- Glyph encoding, segment bits [6:0]:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=D8, 8=80, 9=90 (bit 7 shown as 1).
  - With HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - With HEX_EN=0: codes 10–15 = FF.
- Decimal point: when the shadow dp for digit idx is 1, seg_data[7] is forced to 0, independent of the segment glyph.
- Leading-zero suppression:
  - When shadow lz=1, digit i (i ≥ 1) has segments [6:0] forced to 1 when every shadow nibble from i through DIGITS-1 equals 0.
  - Digit 0 is never suppressed.
  - dp is unaffected by suppression.
- frame_done is registered: it is 1 for the cycle after the cycle where idx = DIGITS-1 and cnt = SCAN_DIV-1.
- Reset values:
  - cnt=0, idx=0.
  - Shadow values, dp and lz all 0.
  - seg_data=8'hFF, digit_sel=all ones, frame_done=0.
- Reset mid-scan: reset takes priority over load and scanning, and all state returns to the reset values on that edge.

## Timing
- Output latency is one cycle: the outputs in cycle t+1 reflect cnt, idx and shadow state in cycle t.
- After rst deasserts (first cycle: cnt=0):
  - Cycle 1: blank.
  - Cycles 2..SCAN_DIV: digit 0.
  - Cycle SCAN_DIV+1: blank.
  - The pattern continues for digits 1, 2, ….
- Each digit is lit for SCAN_DIV-1 cycles. Frame period is DIGITS*SCAN_DIV cycles.
- load at cycle t updates the shadow registers at edge t.
  - The first output that can show the new data appears in cycle t+2.
  - The scan position is not disturbed.
- load on the same cycle as a slot boundary: the capture and the idx advance both occur, with no priority conflict.
- Holding load=1 continuously tracks the inputs every cycle.
- digit_sel never has more than one bit low. Between consecutive lit digits it is all ones for exactly one cycle.

## Test plan
- Reset with DIGITS=4, SCAN_DIV=4:
  - Stimulus: assert rst for 3 cycles, then release.
  - Required: seg_data=FF and digit_sel=1111 through reset and in cycle 1 after release; digit_sel=1110 with seg_data=C0 in cycles 2–4; blank in cycle 5; digit_sel=1101 in cycles 6–8.
- Decode sweep with HEX_EN=0 and HEX_EN=1:
  - Stimulus: load each code 0–F into digit 0.
  - Required: glyph matches the table above (C0…90, then FF or 88/83/C6/A1/86/8E).
- Leading-zero suppression:
  - Stimulus: load values 16'h0030 with lz=1 and dp_in=4'b0100.
  - Required: digit 3 shows FF; digit 2 shows 7F (dp only); digit 1 shows B0; digit 0 shows C0.
  - With lz=0, digit 3 shows C0.
- Load mid-slot:
  - Stimulus: change digit_values without load.
  - Required: display unchanged.
  - Stimulus: pulse load while digit 0 is lit.
  - Required: the new glyph appears exactly 2 cycles later and the slot timing is unchanged.
- frame_done:
  - Required: one-cycle pulses spaced exactly 16 cycles apart (DIGITS=4, SCAN_DIV=4); never asserted during reset.
- Reset mid-scan:
  - Stimulus: assert rst while idx=2.
  - Required: the next cycle shows all reset values; the scan restarts at digit 0; shadow data is cleared (digit 0 shows C0).
